// File: rtl/pipeline_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//   Hazard information from the pipeline stages and the stall/flush/forward
//   controls that come back from the hazard controller.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
);
    logic [REG_ADDR_WIDTH-1:0] id_rs1;
    logic [REG_ADDR_WIDTH-1:0] id_rs2;
    logic [REG_ADDR_WIDTH-1:0] ex_rs1;
    logic [REG_ADDR_WIDTH-1:0] ex_rs2;
    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic                      ex_mem_read;
    logic [REG_ADDR_WIDTH-1:0] mem_rd;
    logic                      mem_reg_write;
    logic [REG_ADDR_WIDTH-1:0] wb_rd;
    logic                      wb_reg_write;
    logic                      branch_taken;
    logic                      mem_req;
    logic                      dmem_ready;

    logic                      pc_en;
    logic                      if_id_en;
    logic                      id_ex_en;
    logic                      ex_mem_en;
    logic                      mem_wb_en;
    logic                      if_id_flush;
    logic                      id_ex_flush;
    logic                      mem_wb_flush;
    logic [1:0]                fwd_a;
    logic [1:0]                fwd_b;
    logic                      mem_fault;
    logic [CNT_WIDTH-1:0]      stall_cycles;
    logic [CNT_WIDTH-1:0]      flush_count;

    // Pipeline datapath side.
    modport master (
        output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_mem_read,
               mem_rd, mem_reg_write, wb_rd, wb_reg_write,
               branch_taken, mem_req, dmem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_wb_flush,
               fwd_a, fwd_b, mem_fault, stall_cycles, flush_count
    );

    // Hazard controller side.
    modport slave (
        input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_mem_read,
               mem_rd, mem_reg_write, wb_rd, wb_reg_write,
               branch_taken, mem_req, dmem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_wb_flush,
               fwd_a, fwd_b, mem_fault, stall_cycles, flush_count
    );
endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Stall/flush/forwarding controller for a 5-stage RISC-V pipeline with
//   data-memory wait sequencing, timeout fault and performance counters.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_TIMEOUT    = 16,
    parameter int CNT_WIDTH      = 32
) (
    input  wire logic              clk,
    input  wire logic              reset,
    pipeline_hazard_ctrl_if.slave  hz
);
    localparam int                        c_wait_w   = $clog2(MEM_TIMEOUT);
    localparam logic [c_wait_w-1:0]       c_wait_one = c_wait_w'(1);
    localparam logic [c_wait_w-1:0]       c_wait_max = c_wait_w'(MEM_TIMEOUT - 1);
    localparam logic [REG_ADDR_WIDTH-1:0] c_x0       = '0;
    localparam logic [CNT_WIDTH-1:0]      c_cnt_one  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_wait_w-1:0]   r_wait_cnt;
    logic                  r_mem_fault;
    logic [CNT_WIDTH-1:0]  r_stall_cycles;
    logic [CNT_WIDTH-1:0]  r_flush_count;

    logic       w_freeze;
    logic       w_load_use;
    logic       w_pc_en;
    logic       w_if_id_en;
    logic       w_id_ex_en;
    logic       w_ex_mem_en;
    logic       w_if_id_flush;
    logic       w_id_ex_flush;
    logic       w_mem_wb_flush;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    // MEM result is younger than WB, so it wins when both match.
    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (hz.mem_reg_write && hz.mem_rd != c_x0 && hz.mem_rd == hz.ex_rs1)
            w_fwd_a = 2'b10;
        else if (hz.wb_reg_write && hz.wb_rd != c_x0 && hz.wb_rd == hz.ex_rs1)
            w_fwd_a = 2'b01;
        if (hz.mem_reg_write && hz.mem_rd != c_x0 && hz.mem_rd == hz.ex_rs2)
            w_fwd_b = 2'b10;
        else if (hz.wb_reg_write && hz.wb_rd != c_x0 && hz.wb_rd == hz.ex_rs2)
            w_fwd_b = 2'b01;
    end

    assign w_freeze   = (hz.mem_req && !hz.dmem_ready) || (r_state == ST_FAULT);
    assign w_load_use = hz.ex_mem_read && (hz.ex_rd != c_x0) &&
                        ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));

    always_comb begin
        w_pc_en        = 1'b1;
        w_if_id_en     = 1'b1;
        w_id_ex_en     = 1'b1;
        w_ex_mem_en    = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_mem_wb_flush = 1'b0;
        if (w_freeze) begin
            // Hold everything upstream of MEM; WB sees a bubble.
            w_pc_en        = 1'b0;
            w_if_id_en     = 1'b0;
            w_id_ex_en     = 1'b0;
            w_ex_mem_en    = 1'b0;
            w_mem_wb_flush = 1'b1;
        end else if (hz.branch_taken) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
        end else if (w_load_use) begin
            w_pc_en       = 1'b0;
            w_if_id_en    = 1'b0;
            w_id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_RUN;
            r_wait_cnt     <= '0;
            r_mem_fault    <= 1'b0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_freeze) begin
                        r_wait_cnt <= c_wait_one;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A dropped request is an abort, treated like completion.
                    if (hz.dmem_ready || !hz.mem_req) begin
                        r_wait_cnt <= '0;
                        r_state    <= ST_RUN;
                    end else if (r_wait_cnt == c_wait_max) begin
                        r_mem_fault <= 1'b1;
                        r_state     <= ST_FAULT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_wait_one;
                    end
                end
                ST_FAULT: r_state <= ST_FAULT;
                default:  r_state <= ST_RUN;
            endcase

            if (!w_pc_en)
                r_stall_cycles <= r_stall_cycles + c_cnt_one;
            if (hz.branch_taken && !w_freeze)
                r_flush_count <= r_flush_count + c_cnt_one;
        end
    end

    assign hz.pc_en        = w_pc_en;
    assign hz.if_id_en     = w_if_id_en;
    assign hz.id_ex_en     = w_id_ex_en;
    assign hz.ex_mem_en    = w_ex_mem_en;
    assign hz.mem_wb_en    = 1'b1;
    assign hz.if_id_flush  = w_if_id_flush;
    assign hz.id_ex_flush  = w_id_ex_flush;
    assign hz.mem_wb_flush = w_mem_wb_flush;
    assign hz.fwd_a        = w_fwd_a;
    assign hz.fwd_b        = w_fwd_b;
    assign hz.mem_fault    = r_mem_fault;
    assign hz.stall_cycles = r_stall_cycles;
    assign hz.flush_count  = r_flush_count;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Directed self-checking bench for pipeline_hazard_ctrl.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_hazard_ctrl;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    pipeline_hazard_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) hz();

    pipeline_hazard_ctrl #(
        .REG_ADDR_WIDTH(5),
        .MEM_TIMEOUT   (16),
        .CNT_WIDTH     (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        hz.id_rs1 = '0; hz.id_rs2 = '0; hz.ex_rs1 = '0; hz.ex_rs2 = '0;
        hz.ex_rd = '0; hz.ex_mem_read = 1'b0; hz.mem_rd = '0;
        hz.mem_reg_write = 1'b0; hz.wb_rd = '0; hz.wb_reg_write = 1'b0;
        hz.branch_taken = 1'b0; hz.mem_req = 1'b0; hz.dmem_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        tick(); tick();
        n_tests++;
        if (hz.mem_fault !== 1'b0 || hz.stall_cycles !== 32'd0 || hz.flush_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_regs: fault=%b stall=%0d flush=%0d, required 0/0/0",
                     hz.mem_fault, hz.stall_cycles, hz.flush_count);
        end
        n_tests++;
        if ({hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en,
             hz.if_id_flush, hz.id_ex_flush, hz.mem_wb_flush} !== 8'b11111_000) begin
            n_fail++;
            $display("FAIL reset_ctrl: en/flush=%b, required 11111000",
                     {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en,
                      hz.if_id_flush, hz.id_ex_flush, hz.mem_wb_flush});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5; hz.id_rs2 = 5'd5; hz.id_rs1 = 5'd9;
        #1;
        n_tests++;
        if ({hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.id_ex_flush, hz.ex_mem_en, hz.mem_wb_en} !== 6'b001111) begin
            n_fail++;
            $display("FAIL load_use_ctrl: pc/ifid/idex/idexfl/exmem/memwb=%b, required 001111",
                     {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.id_ex_flush, hz.ex_mem_en, hz.mem_wb_en});
        end
        tick();
        clear_inputs();
        #1;
        n_tests++;
        if (hz.stall_cycles !== 32'd1 || hz.pc_en !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_once: stall=%0d pc_en=%b, required 1 and 1",
                     hz.stall_cycles, hz.pc_en);
        end
    endtask

    task automatic test_load_use_x0();
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd0; hz.id_rs2 = 5'd0;
        #1;
        n_tests++;
        if ({hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.id_ex_flush} !== 4'b1110) begin
            n_fail++;
            $display("FAIL load_use_x0: pc/ifid/idex/idexfl=%b, required 1110",
                     {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.id_ex_flush});
        end
        tick();
        clear_inputs();
        n_tests++;
        if (hz.stall_cycles !== 32'd1) begin
            n_fail++;
            $display("FAIL load_use_x0_cnt: stall=%0d, required 1", hz.stall_cycles);
        end
    endtask

    task automatic test_forwarding();
        hz.mem_rd = 5'd7; hz.wb_rd = 5'd7; hz.mem_reg_write = 1'b1; hz.wb_reg_write = 1'b1;
        hz.ex_rs1 = 5'd7; hz.ex_rs2 = 5'd3;
        #1;
        n_tests++;
        if (hz.fwd_a !== 2'b10 || hz.fwd_b !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_mem_prio: fwd_a=%b fwd_b=%b, required 10 00", hz.fwd_a, hz.fwd_b);
        end
        hz.mem_reg_write = 1'b0;
        #1;
        n_tests++;
        if (hz.fwd_a !== 2'b01) begin
            n_fail++;
            $display("FAIL fwd_wb: fwd_a=%b, required 01", hz.fwd_a);
        end
        hz.mem_reg_write = 1'b1; hz.mem_rd = 5'd3; hz.ex_rs2 = 5'd7;
        #1;
        n_tests++;
        if (hz.fwd_a !== 2'b01 || hz.fwd_b !== 2'b01) begin
            n_fail++;
            $display("FAIL fwd_b_wb: fwd_a=%b fwd_b=%b, required 01 01", hz.fwd_a, hz.fwd_b);
        end
        hz.mem_rd = 5'd0; hz.wb_rd = 5'd0; hz.ex_rs1 = 5'd0; hz.ex_rs2 = 5'd3;
        #1;
        n_tests++;
        if (hz.fwd_a !== 2'b00 || hz.fwd_b !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_x0: fwd_a=%b fwd_b=%b, required 00 00", hz.fwd_a, hz.fwd_b);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_branch_vs_load_use();
        hz.branch_taken = 1'b1;
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd4; hz.id_rs1 = 5'd4;
        #1;
        n_tests++;
        if ({hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_flush, hz.mem_wb_flush} !== 5'b11110) begin
            n_fail++;
            $display("FAIL branch_prio: pc/ifid/ifidfl/idexfl/memwbfl=%b, required 11110",
                     {hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_flush, hz.mem_wb_flush});
        end
        tick();
        clear_inputs();
        n_tests++;
        if (hz.flush_count !== 32'd1 || hz.stall_cycles !== 32'd1) begin
            n_fail++;
            $display("FAIL branch_cnt: flush=%0d stall=%0d, required 1 1",
                     hz.flush_count, hz.stall_cycles);
        end
    endtask

    task automatic test_mem_wait();
        hz.mem_req = 1'b1; hz.dmem_ready = 1'b0; hz.branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if ({hz.pc_en, hz.ex_mem_en, hz.mem_wb_en, hz.mem_wb_flush, hz.if_id_flush} !== 5'b00110) begin
                n_fail++;
                $display("FAIL mem_wait_frozen[%0d]: pc/exmem/memwb/memwbfl/ifidfl=%b, required 00110",
                         i, {hz.pc_en, hz.ex_mem_en, hz.mem_wb_en, hz.mem_wb_flush, hz.if_id_flush});
            end
            tick();
        end
        hz.dmem_ready = 1'b1; hz.branch_taken = 1'b0;
        #1;
        n_tests++;
        if ({hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_flush} !== 5'b11110) begin
            n_fail++;
            $display("FAIL mem_ready_release: pc/ifid/idex/exmem/memwbfl=%b, required 11110",
                     {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_flush});
        end
        tick();
        clear_inputs();
        n_tests++;
        if (hz.stall_cycles !== 32'd4 || hz.flush_count !== 32'd1 || hz.mem_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL mem_wait_cnt: stall=%0d flush=%0d fault=%b, required 4 1 0",
                     hz.stall_cycles, hz.flush_count, hz.mem_fault);
        end
    endtask

    task automatic test_abort();
        hz.mem_req = 1'b1; hz.dmem_ready = 1'b0;
        tick(); tick();
        hz.mem_req = 1'b0;
        #1;
        n_tests++;
        if (hz.pc_en !== 1'b1 || hz.ex_mem_en !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_release: pc_en=%b ex_mem_en=%b, required 1 1", hz.pc_en, hz.ex_mem_en);
        end
        tick();
        n_tests++;
        if (hz.stall_cycles !== 32'd6) begin
            n_fail++;
            $display("FAIL abort_cnt: stall=%0d, required 6", hz.stall_cycles);
        end
    endtask

    task automatic test_timeout();
        hz.mem_req = 1'b1; hz.dmem_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            n_tests++;
            if (hz.mem_fault !== (i == 16)) begin
                n_fail++;
                $display("FAIL timeout_fault[%0d]: mem_fault=%b, required %b", i, hz.mem_fault, (i == 16));
            end
        end
        hz.dmem_ready = 1'b1;
        #1;
        n_tests++;
        if ({hz.pc_en, hz.ex_mem_en, hz.mem_wb_flush} !== 3'b001) begin
            n_fail++;
            $display("FAIL fault_frozen_ready: pc/exmem/memwbfl=%b, required 001",
                     {hz.pc_en, hz.ex_mem_en, hz.mem_wb_flush});
        end
        tick();
        clear_inputs();
        #1;
        n_tests++;
        if ({hz.pc_en, hz.ex_mem_en, hz.mem_wb_flush, hz.mem_fault} !== 4'b0011) begin
            n_fail++;
            $display("FAIL fault_sticky: pc/exmem/memwbfl/fault=%b, required 0011",
                     {hz.pc_en, hz.ex_mem_en, hz.mem_wb_flush, hz.mem_fault});
        end
        tick();
        n_tests++;
        if (hz.stall_cycles !== 32'd24) begin
            n_fail++;
            $display("FAIL fault_stall_cnt: stall=%0d, required 24", hz.stall_cycles);
        end
        reset = 1'b0;
        #2;
        n_tests++;
        if (hz.mem_fault !== 1'b0 || hz.stall_cycles !== 32'd0 || hz.flush_count !== 32'd0 || hz.pc_en !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: fault=%b stall=%0d flush=%0d pc_en=%b, required 0 0 0 1",
                     hz.mem_fault, hz.stall_cycles, hz.flush_count, hz.pc_en);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        hz.mem_req = 1'b1; hz.dmem_ready = 1'b0;
        tick();
        hz.dmem_ready = 1'b1;
        tick();
        hz.dmem_ready = 1'b0;
        #1;
        n_tests++;
        if (hz.pc_en !== 1'b0 || hz.mem_wb_flush !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_refreeze: pc_en=%b memwbfl=%b, required 0 1", hz.pc_en, hz.mem_wb_flush);
        end
        tick();
        clear_inputs();
        #1;
        n_tests++;
        if (hz.stall_cycles !== 32'd2 || hz.mem_fault !== 1'b0 || hz.pc_en !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_cnt: stall=%0d fault=%b pc_en=%b, required 2 0 1",
                     hz.stall_cycles, hz.mem_fault, hz.pc_en);
        end
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_load_use_x0();
        test_forwarding();
        test_branch_vs_load_use();
        test_mem_wait();
        test_abort();
        test_timeout();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
